ym_ch_seq: RTL and testbench
============================

YM_CH_SEQ -- requirements
Module: ym_ch_seq

Interface
REQ-001 Parameter SLOTS, default 24, number of operator slots per sample (6 channels x 4 operators).
REQ-002 Parameter CH_NUM, default 6, number of channels.
REQ-003 MCLK  in  1  single clock; all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cen  in  1  slot-advance enable; all state advances only when high.
REQ-006 wr_en / wr_ch / wr_alg / wr_pan  in  1/3/3/2  per-channel register write: algorithm and pan {L,R}.
REQ-007 slot  out  5  current operator slot, 0..SLOTS-1.
REQ-008 op1_sel / op_out  out  1/1  accumulator-clear strobe / operator-output-contributes flag.
REQ-009 fsm_dac_load / fsm_dac_out_sel / fsm_dac_ch6  out  1/1/1  output-window timing strobes.
REQ-010 pan  out  2  pan of the channel currently in its output window.
REQ-011 sample_sync  out  1  one-cycle pulse at the start of every sample.

Function
REQ-012 Slot counter increments by 1 per cen cycle and wraps SLOTS-1 -> 0; it holds when cen=0.
REQ-013 Slot decode is op = slot/6, ch = slot%6, with op order 0..3 = OP1, OP3, OP2, OP4.
REQ-014 All outputs are registered and reflect the slot value present before the cen edge (1 cen-cycle latency).
REQ-015 op1_sel is high exactly in OP1 slots (0..5).
REQ-016 op_out is decoded from the active algorithm of ch:
- OP4: always 1.
- OP2: 1 when alg >= 4.
- OP3: 1 when alg >= 5.
- OP1: 1 only when alg = 7.
REQ-017 The output channel is oc = slot/4.
REQ-018 fsm_dac_load is high when slot%4 = 0.
REQ-019 fsm_dac_out_sel is high when slot%4 is 0 or 1.
REQ-020 fsm_dac_ch6 is high when oc = 5.
REQ-021 pan equals the active pan of oc.
REQ-022 sample_sync is high for the single cen cycle in which slot wraps to 0.
REQ-023 Writes go to a shadow register file.
REQ-024 Writes with wr_ch >= CH_NUM are ignored.
REQ-025 When two writes target the same channel, the later one wins.
REQ-026 The shadow file is copied to the active file on the cen edge at the wrap 23 -> 0; a write in that same cycle lands in the active file as well.
REQ-027 Writes are accepted regardless of cen.
REQ-028 Active values never change mid-sample.

Reset
REQ-029 While reset_n = 0, all state is held at its reset value: slot=0, all strobes=0, pan=0, sample_sync=0.
REQ-030 Shadow and active alg reset to 0 and pan to 2'b11 for all channels.
REQ-031 After reset release, the first cen edge outputs slot 0 decode with sample_sync=1.
REQ-032 Reset asserted mid-sample aborts the sample; no partial shadow-to-active copy occurs.

Configuration
REQ-033 Macro YM_CH_SEQ_SYNC_IN_EN, when defined, adds input sync_in (1 bit).
REQ-034 With the macro, sync_in=1 on a cen edge forces slot to 0 and performs the shadow-to-active copy, as at a natural wrap.
REQ-035 Without the macro, the port is absent and the slot counter is free-running.

Structure
REQ-036 Shared package ym_ch_seq_pkg holds:
- SLOTS and CH_NUM constants;
- the op-order enum (OP1, OP3, OP2, OP4);
- the alg_t (3-bit) and pan_t (2-bit) typedefs;
- the op_out decode function.
REQ-037 One sub-module, ym_ch_seq_regs, holds the shadow/active register file with the copy strobe; counter and decode stay in the top module.

Verification
REQ-038 Reset, then cen held at 1 for 48 cycles -> slot goes 0..23 twice; sample_sync high at slot 0 only; op1_sel high for slots 0..5.
REQ-039 Write ch2 alg=4 mid-sample -> op_out unchanged until the next wrap; afterwards op_out=1 at slots 14 (OP2) and 20 (OP4) and 0 at slots 2 and 8.
REQ-040 Write ch5 pan=2'b10 -> after the wrap, pan=2'b10 while fsm_dac_ch6=1 (slots 20..23); fsm_dac_load high at slots 0, 4, ..., 20.
REQ-041 cen toggling 1/0 -> slot and all outputs hold during cen=0 cycles; write with wr_ch=6 -> no register changes.
REQ-042 Assert reset_n at slot 13 after a pending write -> outputs return to reset values; the pending write is lost; restart begins at slot 0.
REQ-043 With YM_CH_SEQ_SYNC_IN_EN defined: sync_in pulse at slot 9 -> next slot is 0; sample_sync=1; pending shadow writes become active.

Source files
------------

// File: rtl/ym_ch_seq_pkg.sv
// rtl/ym_ch_seq_pkg.sv - shared constants, types and operator-output decode for ym_ch_seq
package ym_ch_seq_pkg;

    localparam int SLOTS  = 24;
    localparam int CH_NUM = 6;

    typedef logic [2:0] alg_t;
    typedef logic [1:0] pan_t;

    // Slot order within a sample: all six channels of OP1, then OP3, OP2, OP4.
    typedef enum logic [1:0] {
        OP1 = 2'd0,
        OP3 = 2'd1,
        OP2 = 2'd2,
        OP4 = 2'd3
    } op_e;

    // Whether an operator feeds the channel output for the given algorithm.
    function automatic logic op_out_dec(op_e op, alg_t alg);
        logic res;
        case (op)
            OP4:     res = 1'b1;
            OP2:     res = (alg >= 3'd4);
            OP3:     res = (alg >= 3'd5);
            default: res = (alg == 3'd7);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ym_ch_seq_regs.sv
// rtl/ym_ch_seq_regs.sv - per-channel algorithm/pan shadow and active register file
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en/wr_ch       register write strobe and channel index (out-of-range ignored)
//   wr_alg/wr_pan     values written to the shadow file
//   copy              shadow-to-active transfer strobe (sample boundary)
//   act_alg/act_pan   active values used by the slot decode
module ym_ch_seq_regs
    import ym_ch_seq_pkg::*;
#(
    parameter int CH_NUM = ym_ch_seq_pkg::CH_NUM
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [2:0]              wr_ch,
    input  alg_t                    wr_alg,
    input  pan_t                    wr_pan,
    input  logic                    copy,
    output alg_t [CH_NUM-1:0]       act_alg,
    output pan_t [CH_NUM-1:0]       act_pan
);

    alg_t [CH_NUM-1:0] sh_alg;
    pan_t [CH_NUM-1:0] sh_pan;
    alg_t [CH_NUM-1:0] nxt_alg;
    pan_t [CH_NUM-1:0] nxt_pan;

    // Shadow contents including this cycle's write, so a write coinciding
    // with the copy reaches the active file immediately.
    always_comb begin
        nxt_alg = sh_alg;
        nxt_pan = sh_pan;
        if (wr_en && (32'(wr_ch) < CH_NUM)) begin
            nxt_alg[wr_ch] = wr_alg;
            nxt_pan[wr_ch] = wr_pan;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH_NUM; i++) begin
                sh_alg[i]  <= 3'd0;
                sh_pan[i]  <= 2'b11;
                act_alg[i] <= 3'd0;
                act_pan[i] <= 2'b11;
            end
        end else begin
            sh_alg <= nxt_alg;
            sh_pan <= nxt_pan;
            if (copy) begin
                act_alg <= nxt_alg;
                act_pan <= nxt_pan;
            end
        end
    end

endmodule

// File: rtl/ym_ch_seq.sv
// rtl/ym_ch_seq.sv - operator slot sequencer with per-channel algorithm/pan decode
//
// Optional feature: define YM_CH_SEQ_SYNC_IN_EN to add input sync_in, which
// restarts the sample (slot 0 plus register copy) on a cen edge.
//
// Ports:
//   MCLK, reset_n                 clock, asynchronous active-low reset
//   cen                           slot-advance enable
//   wr_en/wr_ch/wr_alg/wr_pan     channel register write
//   slot                          current operator slot
//   op1_sel, op_out               accumulator-clear strobe, operator contributes
//   fsm_dac_load/out_sel/ch6      output-window strobes
//   pan                           pan of the channel in its output window
//   sample_sync                   first slot of a sample
module ym_ch_seq
    import ym_ch_seq_pkg::*;
#(
    parameter int SLOTS  = ym_ch_seq_pkg::SLOTS,
    parameter int CH_NUM = ym_ch_seq_pkg::CH_NUM
) (
    input  logic       MCLK,
    input  logic       reset_n,
    input  logic       cen,
`ifdef YM_CH_SEQ_SYNC_IN_EN
    input  logic       sync_in,
`endif
    input  logic       wr_en,
    input  logic [2:0] wr_ch,
    input  alg_t       wr_alg,
    input  pan_t       wr_pan,
    output logic [4:0] slot,
    output logic       op1_sel,
    output logic       op_out,
    output logic       fsm_dac_load,
    output logic       fsm_dac_out_sel,
    output logic       fsm_dac_ch6,
    output pan_t       pan,
    output logic       sample_sync
);

    localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);
    localparam logic [2:0] CH_LAST   = 3'(CH_NUM - 1);

    // cnt is the live slot; ch_cnt/op_cnt track slot%6 and slot/6 alongside it.
    logic [4:0] cnt;
    logic [2:0] ch_cnt;
    logic [1:0] op_cnt;
    logic       restart;
    logic       copy;

    alg_t [CH_NUM-1:0] act_alg;
    pan_t [CH_NUM-1:0] act_pan;

`ifdef YM_CH_SEQ_SYNC_IN_EN
    assign restart = (cnt == SLOT_LAST) || sync_in;
`else
    assign restart = (cnt == SLOT_LAST);
`endif
    assign copy = cen && restart;

    ym_ch_seq_regs #(
        .CH_NUM (CH_NUM)
    ) u_regs (
        .clk     (MCLK),
        .rst_n   (reset_n),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_alg  (wr_alg),
        .wr_pan  (wr_pan),
        .copy    (copy),
        .act_alg (act_alg),
        .act_pan (act_pan)
    );

    // Output channel is slot/4, i.e. cnt[4:2]; slot%4 is cnt[1:0].
    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            cnt             <= 5'd0;
            ch_cnt          <= 3'd0;
            op_cnt          <= 2'd0;
            slot            <= 5'd0;
            op1_sel         <= 1'b0;
            op_out          <= 1'b0;
            fsm_dac_load    <= 1'b0;
            fsm_dac_out_sel <= 1'b0;
            fsm_dac_ch6     <= 1'b0;
            pan             <= 2'b00;
            sample_sync     <= 1'b0;
        end else if (cen) begin
            slot            <= cnt;
            op1_sel         <= (op_e'(op_cnt) == OP1);
            op_out          <= op_out_dec(op_e'(op_cnt), act_alg[ch_cnt]);
            fsm_dac_load    <= (cnt[1:0] == 2'd0);
            fsm_dac_out_sel <= ~cnt[1];
            fsm_dac_ch6     <= (cnt[4:2] == 3'd5);
            pan             <= act_pan[cnt[4:2]];
            sample_sync     <= (cnt == 5'd0);
            if (restart) begin
                cnt    <= 5'd0;
                ch_cnt <= 3'd0;
                op_cnt <= 2'd0;
            end else begin
                cnt <= cnt + 5'd1;
                if (ch_cnt == CH_LAST) begin
                    ch_cnt <= 3'd0;
                    op_cnt <= op_cnt + 2'd1;
                end else begin
                    ch_cnt <= ch_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ym_ch_seq.sv
// tb/tb_ym_ch_seq.sv - self-checking bench for ym_ch_seq
module tb_ym_ch_seq;

    logic       MCLK = 1'b0;
    logic       reset_n = 1'b0;
    logic       cen = 1'b0;
    logic       sync_in = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_ch = 3'd0;
    logic [2:0] wr_alg = 3'd0;
    logic [1:0] wr_pan = 2'd0;
    logic [4:0] slot;
    logic       op1_sel, op_out, fsm_dac_load, fsm_dac_out_sel, fsm_dac_ch6, sample_sync;
    logic [1:0] pan;

    int n_cmp = 0;
    int n_fail = 0;
    int m_alg[6];
    int m_pan[6];

    always #5 MCLK = ~MCLK;

    ym_ch_seq dut (
        .MCLK            (MCLK),
        .reset_n         (reset_n),
        .cen             (cen),
`ifdef YM_CH_SEQ_SYNC_IN_EN
        .sync_in         (sync_in),
`endif
        .wr_en           (wr_en),
        .wr_ch           (wr_ch),
        .wr_alg          (wr_alg),
        .wr_pan          (wr_pan),
        .slot            (slot),
        .op1_sel         (op1_sel),
        .op_out          (op_out),
        .fsm_dac_load    (fsm_dac_load),
        .fsm_dac_out_sel (fsm_dac_out_sel),
        .fsm_dac_ch6     (fsm_dac_ch6),
        .pan             (pan),
        .sample_sync     (sample_sync)
    );

    typedef struct {
        logic       cen;
        logic       wr_en;
        logic [2:0] wr_ch;
        logic [2:0] wr_alg;
        logic [1:0] wr_pan;
        int         slot;
        int         sync;
        int         op1;
        int         load;
        int         sel;
        int         ch6;
        int         op_out;
        int         pan;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int s, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at expected slot %0d: got %0d, want %0d", name, s, act, exp);
        end
    endtask

    task automatic step();
        @(posedge MCLK);
        @(negedge MCLK);
    endtask

    function automatic int exp_op_out(input int s, input int alg);
        case (s / 6)
            0:       return (alg == 7) ? 1 : 0;
            1:       return (alg >= 5) ? 1 : 0;
            2:       return (alg >= 4) ? 1 : 0;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 6; c++) begin
            m_alg[c] = 0;
            m_pan[c] = 3;
        end
    endtask

    // One cen=1 step per slot, full output check against the bench model.
    task automatic check_slots(input int first, input int last);
        for (int s = first; s <= last; s++) begin
            cen = 1'b1;
            step();
            check("slot", s, int'(slot), s);
            check("sample_sync", s, int'(sample_sync), (s == 0) ? 1 : 0);
            check("op1_sel", s, int'(op1_sel), (s < 6) ? 1 : 0);
            check("op_out", s, int'(op_out), exp_op_out(s, m_alg[s % 6]));
            check("dac_load", s, int'(fsm_dac_load), (s % 4 == 0) ? 1 : 0);
            check("dac_out_sel", s, int'(fsm_dac_out_sel), (s % 4 < 2) ? 1 : 0);
            check("dac_ch6", s, int'(fsm_dac_ch6), (s / 4 == 5) ? 1 : 0);
            check("pan", s, int'(pan), m_pan[s / 4]);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_slot", 0, int'(slot), 0);
        check("rst_op1_sel", 0, int'(op1_sel), 0);
        check("rst_op_out", 0, int'(op_out), 0);
        check("rst_load", 0, int'(fsm_dac_load), 0);
        check("rst_out_sel", 0, int'(fsm_dac_out_sel), 0);
        check("rst_ch6", 0, int'(fsm_dac_ch6), 0);
        check("rst_pan", 0, int'(pan), 0);
        check("rst_sync", 0, int'(sample_sync), 0);
    endtask

    task automatic do_write(input int ch, input int alg, input int pn);
        wr_en  = 1'b1;
        wr_ch  = 3'(ch);
        wr_alg = 3'(alg);
        wr_pan = 2'(pn);
    endtask

    initial begin
        // cen toggling with out-of-range writes; slot 0 onwards after a wrap
        //          cen  wen ch    alg   pan   slot syn op1 ld sel ch6 oo pan
        vecs[0] = '{1'b1,1'b0,3'd0,3'd0,2'd0, 0,   1,  1,  1, 1,  0,  0, 3};
        vecs[1] = '{1'b0,1'b1,3'd6,3'd7,2'd0, 0,   1,  1,  1, 1,  0,  0, 3};
        vecs[2] = '{1'b1,1'b1,3'd6,3'd7,2'd0, 1,   0,  1,  0, 1,  0,  0, 3};
        vecs[3] = '{1'b0,1'b1,3'd7,3'd5,2'd1, 1,   0,  1,  0, 1,  0,  0, 3};
        vecs[4] = '{1'b0,1'b0,3'd0,3'd0,2'd0, 1,   0,  1,  0, 1,  0,  0, 3};
        vecs[5] = '{1'b1,1'b1,3'd7,3'd7,2'd0, 2,   0,  1,  0, 0,  0,  0, 3};
        vecs[6] = '{1'b1,1'b0,3'd0,3'd0,2'd0, 3,   0,  1,  0, 0,  0,  0, 3};
        vecs[7] = '{1'b0,1'b1,3'd6,3'd4,2'd2, 3,   0,  1,  0, 0,  0,  0, 3};

        model_reset();

        // Reset held with cen active: everything stays at reset value.
        cen = 1'b1;
        repeat (3) step();
        check_reset_outputs();

        // Release and run two full samples.
        @(negedge MCLK);
        reset_n = 1'b1;
        check_slots(0, 23);
        check_slots(0, 23);

        // cen gating and ignored out-of-range writes.
        for (int i = 0; i < 8; i++) begin
            cen    = vecs[i].cen;
            wr_en  = vecs[i].wr_en;
            wr_ch  = vecs[i].wr_ch;
            wr_alg = vecs[i].wr_alg;
            wr_pan = vecs[i].wr_pan;
            step();
            check("tbl_slot", vecs[i].slot, int'(slot), vecs[i].slot);
            check("tbl_sync", vecs[i].slot, int'(sample_sync), vecs[i].sync);
            check("tbl_op1_sel", vecs[i].slot, int'(op1_sel), vecs[i].op1);
            check("tbl_load", vecs[i].slot, int'(fsm_dac_load), vecs[i].load);
            check("tbl_out_sel", vecs[i].slot, int'(fsm_dac_out_sel), vecs[i].sel);
            check("tbl_ch6", vecs[i].slot, int'(fsm_dac_ch6), vecs[i].ch6);
            check("tbl_op_out", vecs[i].slot, int'(op_out), vecs[i].op_out);
            check("tbl_pan", vecs[i].slot, int'(pan), vecs[i].pan);
        end
        wr_en = 1'b0;
        check_slots(4, 23);
        check_slots(0, 9);

        // Mid-sample writes stay in the shadow file until the wrap; later write wins.
        do_write(2, 4, 3);
        check_slots(10, 10);
        do_write(5, 7, 1);
        check_slots(11, 11);
        do_write(5, 0, 2);
        check_slots(12, 12);
        wr_en = 1'b0;
        check_slots(13, 23);
        m_alg[2] = 4;
        m_pan[5] = 2;
        check_slots(0, 23);

        // A write on the wrap edge itself becomes active for the next sample.
        check_slots(0, 22);
        do_write(0, 7, 1);
        check_slots(23, 23);
        wr_en = 1'b0;
        m_alg[0] = 7;
        m_pan[0] = 1;
        check_slots(0, 23);

        // Reset mid-sample with a pending write: the write is lost.
        check_slots(0, 12);
        do_write(1, 5, 0);
        check_slots(13, 13);
        wr_en = 1'b0;
        reset_n = 1'b0;
        step();
        step();
        check_reset_outputs();
        reset_n = 1'b1;
        model_reset();
        check_slots(0, 23);
        check_slots(0, 23);

`ifdef YM_CH_SEQ_SYNC_IN_EN
        // sync_in restarts the sample and applies pending shadow writes.
        check_slots(0, 4);
        do_write(3, 6, 1);
        check_slots(5, 5);
        wr_en = 1'b0;
        check_slots(6, 8);
        sync_in = 1'b1;
        check_slots(9, 9);
        sync_in = 1'b0;
        m_alg[3] = 6;
        m_pan[3] = 1;
        check_slots(0, 23);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
